// File: rtl/axis_baser_rx_64.sv
// axis_baser_rx_64: 10GBASE-R 64b/66b block receiver to AXI4-Stream.
// Strips and checks the preamble/SFD and realigns lane-4 starts onto lane 0.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   encoded_rx_data/_hdr         one decoded 66b block per cycle
//   m_axis_t*                    payload stream incl. FCS, no backpressure
//   start_packet_0/_4            pulse on an accepted lane-0/lane-4 start
//   error_bad_block/_bad_frame   pulse on a bad block / aborted or dropped frame
module axis_baser_rx_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_rx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  start_packet_0,
  output logic                  start_packet_4,
  output logic                  error_bad_block,
  output logic                  error_bad_frame
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE4,
    S_PAYLOAD,
    S_LAST
  } state_t;

  state_t r_state, w_state;

  logic [DATA_WIDTH-1:0] r_hold, w_hold;
  logic                  r_hold_vld, w_hold_vld;
  logic                  r_lane4, w_lane4;
  logic [KEEP_WIDTH-1:0] r_lkeep, w_lkeep;

  logic [DATA_WIDTH-1:0] r_tdata, w_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep, w_tkeep;
  logic r_tvalid, w_tvalid;
  logic r_tlast, w_tlast;
  logic r_tuser, w_tuser;
  logic r_sp0, w_sp0;
  logic r_sp4, w_sp4;
  logic r_bblk, w_bblk;
  logic r_bfrm, w_bfrm;

  logic [7:0]            w_type;
  logic                  w_is_data, w_is_ctrl;
  logic                  w_start0, w_start4, w_idle;
  logic                  w_term_type, w_term, w_bad;
  logic [3:0]            w_k;
  logic                  w_pre0_ok, w_pre4a_ok, w_pre4b_ok;
  logic [DATA_WIDTH-1:0] w_t;
  logic                  w_chk_start;

  function automatic logic [7:0] keep_of(input logic [3:0] n);
    return 8'hFF >> (4'd8 - n);
  endfunction

  assign w_type     = encoded_rx_data[7:0];
  assign w_is_data  = encoded_rx_hdr == 2'b01;
  assign w_is_ctrl  = encoded_rx_hdr == 2'b10;
  assign w_start0   = w_is_ctrl && w_type == 8'h78;
  assign w_start4   = w_is_ctrl && w_type == 8'h33;
  assign w_idle     = w_is_ctrl && w_type == 8'h1E;
  assign w_term     = w_is_ctrl && w_term_type;
  assign w_bad      = !(w_is_data || w_start0 || w_start4 ||
                        w_idle || w_term);
  assign w_pre0_ok  = encoded_rx_data[63:8] == 56'hD5_5555_5555_5555;
  assign w_pre4a_ok = encoded_rx_data[63:40] == 24'h55_5555;
  assign w_pre4b_ok = encoded_rx_data[31:0] == 32'hD555_5555;
  // Terminate bytes shifted down so block byte 1 lands in lane 0.
  assign w_t        = {8'h00, encoded_rx_data[63:8]};

  always_comb begin
    w_term_type = 1'b1;
    w_k         = 4'd0;
    case (w_type)
      8'h87:   w_k = 4'd0;
      8'h99:   w_k = 4'd1;
      8'hAA:   w_k = 4'd2;
      8'hB4:   w_k = 4'd3;
      8'hCC:   w_k = 4'd4;
      8'hD2:   w_k = 4'd5;
      8'hE1:   w_k = 4'd6;
      8'hFF:   w_k = 4'd7;
      default: w_term_type = 1'b0;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_hold      = r_hold;
    w_hold_vld  = r_hold_vld;
    w_lane4     = r_lane4;
    w_lkeep     = r_lkeep;
    w_tdata     = '0;
    w_tkeep     = '0;
    w_tvalid    = 1'b0;
    w_tlast     = 1'b0;
    w_tuser     = 1'b0;
    w_sp0       = 1'b0;
    w_sp4       = 1'b0;
    w_bblk      = 1'b0;
    w_bfrm      = 1'b0;
    w_chk_start = 1'b0;
    unique case (r_state)
      S_IDLE: w_chk_start = 1'b1;
      S_LAST: begin
        w_tvalid    = 1'b1;
        w_tdata     = r_hold;
        w_tkeep     = r_lkeep;
        w_tlast     = 1'b1;
        w_chk_start = 1'b1;
      end
      S_PRE4: begin
        if (w_is_data && w_pre4b_ok) begin
          w_hold  = encoded_rx_data;
          w_state = S_PAYLOAD;
        end else begin
          w_bfrm  = 1'b1;
          w_bblk  = w_bad;
          w_state = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (w_is_data) begin
          w_tvalid   = r_lane4 || r_hold_vld;
          w_tkeep    = w_tvalid ? 8'hFF : 8'h00;
          w_tdata    = r_lane4 ?
                       {encoded_rx_data[31:0], r_hold[63:32]} : r_hold;
          w_hold     = encoded_rx_data;
          w_hold_vld = 1'b1;
        end else if (w_term) begin
          w_state = S_IDLE;
          if (r_lane4) begin
            w_tvalid = 1'b1;
            w_tdata  = {w_t[31:0], r_hold[63:32]};
            if (w_k <= 4'd4) begin
              w_tkeep = keep_of(4'd4 + w_k);
              w_tlast = 1'b1;
            end else begin
              w_tkeep = 8'hFF;
              w_hold  = {32'h0, w_t[63:32]};
              w_lkeep = keep_of(w_k - 4'd4);
              w_state = S_LAST;
            end
          end else if (w_k == 4'd0) begin
            // Nothing held means nothing was received: runt.
            w_tvalid = r_hold_vld;
            w_tdata  = r_hold;
            w_tkeep  = r_hold_vld ? 8'hFF : 8'h00;
            w_tlast  = r_hold_vld;
            w_bfrm   = !r_hold_vld;
          end else begin
            w_tvalid = r_hold_vld;
            w_tdata  = r_hold;
            w_tkeep  = r_hold_vld ? 8'hFF : 8'h00;
            w_hold   = w_t;
            w_lkeep  = keep_of(w_k);
            w_state  = S_LAST;
          end
        end else begin
          // Abort: flush what is held as a bad last beat.
          w_tvalid    = r_lane4 || r_hold_vld;
          w_tdata     = r_lane4 ? {32'h0, r_hold[63:32]} : r_hold;
          w_tkeep     = r_lane4 ? 8'h0F : (r_hold_vld ? 8'hFF : 8'h00);
          w_tlast     = w_tvalid;
          w_tuser     = w_tvalid;
          w_bfrm      = 1'b1;
          w_chk_start = 1'b1;
        end
      end
    endcase
    if (w_chk_start) begin
      w_state = S_IDLE;
      if (w_is_data || w_bad) begin
        w_bblk = 1'b1;
      end else if (w_start0) begin
        if (w_pre0_ok) begin
          w_sp0      = 1'b1;
          w_lane4    = 1'b0;
          w_hold_vld = 1'b0;
          w_state    = S_PAYLOAD;
        end else begin
          w_bfrm = 1'b1;
        end
      end else if (w_start4) begin
        if (w_pre4a_ok) begin
          w_sp4      = 1'b1;
          w_lane4    = 1'b1;
          w_hold_vld = 1'b0;
          w_state    = S_PRE4;
        end else begin
          w_bfrm = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_lane4    <= 1'b0;
      r_lkeep    <= '0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_sp0      <= 1'b0;
      r_sp4      <= 1'b0;
      r_bblk     <= 1'b0;
      r_bfrm     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_hold     <= w_hold;
      r_hold_vld <= w_hold_vld;
      r_lane4    <= w_lane4;
      r_lkeep    <= w_lkeep;
      r_tdata    <= w_tdata;
      r_tkeep    <= w_tkeep;
      r_tvalid   <= w_tvalid;
      r_tlast    <= w_tlast;
      r_tuser    <= w_tuser;
      r_sp0      <= w_sp0;
      r_sp4      <= w_sp4;
      r_bblk     <= w_bblk;
      r_bfrm     <= w_bfrm;
    end
  end

  assign m_axis_tdata    = r_tdata;
  assign m_axis_tkeep    = r_tkeep;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign m_axis_tuser    = r_tuser;
  assign start_packet_0  = r_sp0;
  assign start_packet_4  = r_sp4;
  assign error_bad_block = r_bblk;
  assign error_bad_frame = r_bfrm;

endmodule
